// File: rtl/req_arbiter_pkg.sv
// ============================================================================
// arb_pkg : shared types and defaults for the req_arbiter block
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

    localparam int MAX_HOLD_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/req_arbiter_pick.sv
// ============================================================================
// arb_pick : combinational winner selection, fixed priority or round-robin
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_pick
    import arb_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    input  arb_mode_t     mode,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW:0]    start;
    int             sum;

    always_comb begin
        doubled = {eligible, eligible};
        start   = {1'b0, rr_ptr} + 1'b1;
        // rotated[0] is the requester just after the last winner
        rotated = N'(doubled >> start);
        found   = 1'b0;
        winner  = '0;
        sum     = 0;
        unique case (mode)
            ARB_FIXED: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (eligible[i]) begin
                        found  = 1'b1;
                        winner = IW'(i);
                    end
                end
            end
            ARB_RR: begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (rotated[k]) begin
                        sum = int'(start) + k;
                        if (sum >= N) begin
                            sum = sum - N;
                        end
                        found  = 1'b1;
                        winner = IW'(sum);
                    end
                end
            end
            default: begin
                found  = 1'b0;
                winner = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/req_arbiter.sv
// ============================================================================
// req_arbiter : registered, timeout-protected N-way grant onto one result bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module req_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 3,
    parameter  int DW       = 8,
    parameter  int MAX_HOLD = MAX_HOLD_DEFAULT,
    localparam int IW       = $clog2(N),
    localparam int HW       = $clog2(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_id,
    output logic [DW-1:0]   dout,
    output logic [HW-1:0]   hold_cnt,
    output logic            err_timeout
);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  blocked_q, blocked_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          err_q, err_d;

    logic [N-1:0]  req_clean;
    logic [N-1:0]  timeout_mask;
    logic [N-1:0]  eligible;
    logic          owner_req;
    logic          timeout;
    logic          arbitrate;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // Unknown request bits never win: case matching sends X/Z to default
    always_comb begin
        req_clean = '0;
        for (int i = 0; i < N; i++) begin
            case (req[i])
                1'b1:    req_clean[i] = 1'b1;
                default: req_clean[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        owner_req    = req_clean[owner_q];
        timeout      = (state_q == BUSY) && owner_req && (hold_q == HW'(MAX_HOLD - 1));
        timeout_mask = timeout ? gnt_q : '0;
        eligible     = req_clean & ~blocked_q & ~timeout_mask;
    end

    arb_pick #(
        .N (N)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .mode     (arb_mode_t'(mode)),
        .winner   (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        err_d     = timeout;
        arbitrate = 1'b0;
        // A dropped request unblocks; a timed-out owner becomes blocked
        blocked_d = (blocked_q & req_clean) | timeout_mask;

        unique case (state_q)
            IDLE: arbitrate = 1'b1;
            BUSY: begin
                if (!owner_req || timeout) begin
                    arbitrate = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: arbitrate = 1'b1;
        endcase

        if (arbitrate) begin
            hold_d = '0;
            if (pick_found) begin
                state_d  = BUSY;
                gnt_d    = N'(1) << pick_idx;
                owner_d  = pick_idx;
                rr_ptr_d = pick_idx;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= IW'(N - 1);
            hold_q    <= '0;
            err_q     <= 1'b0;
            blocked_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            blocked_q <= blocked_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_valid   = (state_q == BUSY);
    assign gnt_id      = owner_q;
    assign hold_cnt    = hold_q;
    assign err_timeout = err_q;
    assign dout        = gnt_valid ? din[owner_q*DW +: DW] : '0;

    a_req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));
    a_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_valid:     assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt_q));
    a_owner_hold: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == BUSY && owner_req && !timeout) |=> $stable(gnt_q));

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter.sv
// ============================================================================
// tb_req_arbiter : directed vectors with a cycle-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_req_arbiter;

    localparam int N        = 3;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode  = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N*DW-1:0] din   = {8'h33, 8'h22, 8'h11};
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [1:0]      gnt_id;
    logic [DW-1:0]   dout;
    logic [1:0]      hold_cnt;
    logic            err_timeout;

    int checks = 0;
    int errors = 0;

    // Reference state: owner index (-1 = idle), hold count, rr pointer, blocked set
    int           m_owner = -1;
    int           m_hold  = 0;
    int           m_rr    = N - 1;
    bit [N-1:0]   m_blk   = '0;
    bit           m_err   = 1'b0;

    req_arbiter #(.N(N), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .req         (req),
        .din         (din),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .dout        (dout),
        .hold_cnt    (hold_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_next(
        input  logic [N-1:0] r,
        input  logic         md,
        input  int           owner,
        input  int           hold,
        input  int           rr,
        input  bit [N-1:0]   blk,
        output int           n_owner,
        output int           n_hold,
        output int           n_rr,
        output bit [N-1:0]   n_blk,
        output bit           n_err
    );
        bit rearb;
        int win;
        int cand;
        n_owner = owner;
        n_hold  = hold;
        n_rr    = rr;
        n_err   = 1'b0;
        rearb   = 1'b0;
        for (int i = 0; i < N; i++) n_blk[i] = blk[i] && (r[i] === 1'b1);
        if (owner < 0) begin
            rearb = 1'b1;
        end else if (r[owner] !== 1'b1) begin
            rearb = 1'b1;
        end else if (hold == MAX_HOLD - 1) begin
            rearb        = 1'b1;
            n_err        = 1'b1;
            n_blk[owner] = 1'b1;
        end else begin
            n_hold = hold + 1;
        end
        if (rearb) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                cand = md ? (rr + 1 + k) % N : k;
                if (win < 0 && r[cand] === 1'b1 && !blk[cand] && !(n_err && cand == owner))
                    win = cand;
            end
            n_owner = win;
            n_hold  = 0;
            if (win >= 0) n_rr = win;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_rr    <= N - 1;
            m_blk   <= '0;
            m_err   <= 1'b0;
        end else begin : model_upd
            int         o, h, rp;
            bit [N-1:0] b;
            bit         e;
            model_next(req, mode, m_owner, m_hold, m_rr, m_blk, o, h, rp, b, e);
            m_owner <= o;
            m_hold  <= h;
            m_rr    <= rp;
            m_blk   <= b;
            m_err   <= e;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] e_gnt, e_id, e_dout;
        e_gnt  = 0;
        e_id   = 0;
        e_dout = 0;
        if (m_owner >= 0) begin
            e_gnt  = 32'd1 << m_owner;
            e_id   = 32'(m_owner);
            e_dout = 32'(din[m_owner*DW +: DW]);
        end
        chk("model_gnt",       32'(gnt),         e_gnt);
        chk("model_gnt_valid", 32'(gnt_valid),   32'(m_owner >= 0));
        chk("model_gnt_id",    32'(gnt_id),      e_id);
        chk("model_dout",      32'(dout),        e_dout);
        chk("model_hold_cnt",  32'(hold_cnt),    (m_owner >= 0) ? 32'(m_hold) : 32'd0);
        chk("model_err",       32'(err_timeout), 32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin schedule: request vector applied after each granted cycle
    logic [N-1:0] rr_next [9] = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111,
                                  3'b011, 3'b111, 3'b110, 3'b000};
    int           rr_id   [9] = '{0, 0, 1, 1, 2, 2, 0, 0, 1};

    initial begin
        step();
        step();
        chk("rst_gnt",   32'(gnt),         32'd0);
        chk("rst_valid", 32'(gnt_valid),   32'd0);
        chk("rst_id",    32'(gnt_id),      32'd0);
        chk("rst_hold",  32'(hold_cnt),    32'd0);
        chk("rst_err",   32'(err_timeout), 32'd0);
        chk("rst_dout",  32'(dout),        32'd0);
        rst_n = 1'b1;

        // fixed priority
        req = 3'b110;
        step();
        chk("fix_gnt1",  32'(gnt),  32'b010);
        chk("fix_dout1", 32'(dout), 32'h22);
        req = 3'b100;
        step();
        chk("fix_gnt2",  32'(gnt),      32'b100);
        chk("fix_hold2", 32'(hold_cnt), 32'd0);
        chk("fix_dout2", 32'(dout),     32'h33);
        req = 3'b000;
        step();
        chk("fix_idle", 32'(gnt_valid), 32'd0);

        // idle bus stays quiet
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_valid", 32'(gnt_valid),   32'd0);
            chk("idle_id",    32'(gnt_id),      32'd0);
            chk("idle_dout",  32'(dout),        32'd0);
            chk("idle_err",   32'(err_timeout), 32'd0);
        end

        // round-robin hand-offs without bubbles
        mode = 1'b1;
        req  = 3'b111;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rr_valid", 32'(gnt_valid), 32'd1);
            chk("rr_id",    32'(gnt_id),    32'(rr_id[k]));
            chk("rr_hold",  32'(hold_cnt),  32'(k % 2));
            req = rr_next[k];
        end
        step();
        chk("rr_end_idle", 32'(gnt_valid), 32'd0);

        // single-requester timeout and re-grant
        mode = 1'b0;
        req  = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("to_gnt",  32'(gnt),         (k <= 4) ? 32'b001 : 32'd0);
            chk("to_err",  32'(err_timeout), 32'(k == 5));
            chk("to_hold", 32'(hold_cnt),    (k <= 4) ? 32'(k - 1) : 32'd0);
        end
        req = 3'b000;
        step();
        req = 3'b001;
        step();
        chk("to_regrant", 32'(gnt), 32'b001);
        req = 3'b000;
        step();

        // timeout hand-off under fixed priority
        req = 3'b011;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("ho_gnt", 32'(gnt), (k <= 4) ? 32'b001 : (k <= 8) ? 32'b010 : 32'd0);
            chk("ho_err", 32'(err_timeout), 32'(k == 5 || k == 9));
        end
        req = 3'b000;
        step();

        // asynchronous reset while busy
        mode = 1'b1;
        req  = 3'b111;
        step();
        chk("ar_busy", 32'(gnt_valid), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt",   32'(gnt),       32'd0);
        chk("ar_valid", 32'(gnt_valid), 32'd0);
        chk("ar_hold",  32'(hold_cnt),  32'd0);
        req = 3'b000;
        step();
        rst_n = 1'b1;
        req   = 3'b111;
        step();
        chk("ar_first_rr", 32'(gnt), 32'b001);
        req = 3'b000;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Sequential arbiter that shares one 8-bit result bus between N requesters.
- Grant is held until the owner releases its request or a hold timeout fires.
- Two policies, selected at run time: fixed priority (req[0] highest) or round-robin.
- Sits in front of the shared datapath and drives its select, replacing static priority-case selection with a registered, fair, timeout-protected grant.

Parameters:
- N, 3, number of requesters (2..8).
- DW, 8, data width per requester.
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- req  input  N  request per requester, level-sensitive.
- din  input  N*DW  packed data; requester i occupies din[i*DW +: DW].
- gnt  output  N  one-hot grant, all-zero when idle.
- gnt_valid  output  1  1 while any grant is active.
- gnt_id  output  $clog2(N)  index of owner; 0 when gnt_valid=0.
- dout  output  DW  din slice of owner; 0 when gnt_valid=0.
- hold_cnt  output  $clog2(MAX_HOLD)  cycles the current owner has held, 0 on the first grant cycle.
- err_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE; gnt, gnt_valid, gnt_id, hold_cnt, err_timeout = 0.
  - blocked mask = 0; rr pointer = N-1, so the first round-robin search starts at index 0.
- State IDLE:
  - If any eligible request (req & ~blocked) exists, the next edge loads the winner and moves to BUSY.
  - Latency from req to gnt is 1 cycle.
- State BUSY:
  - gnt holds its one-hot value; hold_cnt increments each cycle.
  - Release: req[owner]=0 sampled, so re-arbitrate on the same edge.
    - Eligible request present: new winner granted next cycle, no bubble, hold_cnt=0.
    - Otherwise: go to IDLE with gnt=0.
  - Timeout: req[owner]=1 with hold_cnt==MAX_HOLD-1.
    - Next edge revokes the grant, pulses err_timeout for 1 cycle, and sets blocked[owner].
    - Re-arbitrates among the others exactly as for a release.
- Blocked mask:
  - blocked[i] clears on the edge where req[i] is sampled 0.
  - A blocked requester cannot win until its request has dropped and been re-asserted.
- Fixed priority: the lowest eligible index wins.
- Round-robin:
  - Search starts at rr_ptr+1 and wraps modulo N; the first eligible index wins.
  - rr_ptr updates to the winner at each grant.
  - In fixed mode rr_ptr still tracks the winner.
- mode is sampled only at arbitration edges; a change mid-grant does not affect the current owner.
- dout = din[gnt_id*DW +: DW], combinational from the registered owner. No data latency beyond the grant.
- Simultaneous release and new request by the same requester: the released owner is eligible again.
  - Fixed mode: it can win immediately.
  - Round-robin mode: it is searched last.
- req bits that are X or Z are treated as 0 for arbitration. Simulation reports an error via an assertion.
- Invariants, enforced by assertions: $onehot0(gnt); gnt_valid == |gnt; the owner never changes while BUSY without a release or timeout edge.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;
  - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
  - localparam default MAX_HOLD.
- Sub-module arb_pick: purely combinational.
  - Inputs: eligible vector, rr_ptr, mode.
  - Outputs: winner index and found flag.
  - Implemented with unique/priority case over the rotated request vector.
- The top level holds the FSM, counters, masks and output mux.

Test Plan:
- Fixed priority, N=3: req=3'b110 -> gnt=3'b010 at the next edge. Drop req[1] -> gnt=3'b100 one edge later, hold_cnt=0, dout=din[23:16].
- Round-robin: each requester holds req=1 for 2 granted cycles then drops and re-raises -> owner sequence 0,1,2,0,1 with no idle gaps.
- Timeout, MAX_HOLD=4: req=3'b001 held for 8 cycles.
  - gnt=3'b001 for 4 cycles, err_timeout pulse on the 5th, then gnt=0.
  - req[0] drops and re-asserts -> regranted 1 cycle later.
- Timeout handoff: req=3'b011 constant in fixed mode.
  - req[0] granted 4 cycles, then timeout -> gnt=3'b010.
  - req[1] granted 4 cycles, then timeout -> gnt=0 (both blocked).
- Idle: req=0 -> gnt_valid=0, gnt_id=0, dout=8'd0, err_timeout=0 indefinitely.
- Reset mid-grant: rst_n=0 asynchronously during BUSY -> gnt=0 immediately without waiting for clk. After release, req=3'b111 in round-robin -> first grant to index 0.
